maxnet_feeder: RTL and testbench
================================

Name: maxnet_feeder

Overview:
- Upstream/downstream wrapper stage for Maxnet.
- Accepts a stream of FP32 activations over a valid/ready handshake and groups them into sets of four.
- Sanitizes each set, presents it stable on Maxnet's num1..num4/epsilon inputs, pulses start, waits for done, and returns the winning value plus its slot index on a result handshake.
- A watchdog bounds the wait on Maxnet.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in WAIT before abandoning the set; must be ≥ 2.
- TW, 11: width of the watchdog counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  FP32 activation.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder can accept in_data.
- eps_cfg  in  32  FP32 epsilon; sampled when the 4th activation is accepted.
- num1, num2, num3, num4  out  32 each  sanitized activations to Maxnet, slot 0..3.
- epsilon  out  32  latched epsilon to Maxnet.
- mx_start  out  1  one-cycle start pulse to Maxnet.
- mx_max  in  32  Maxnet max output.
- mx_done  in  1  Maxnet done.
- res_max  out  32  winning value.
- res_index  out  2  slot of winner, 0..3.
- res_err  out  1  1 = timeout or no slot matches mx_max.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset (rst=1 at clk edge), all registers cleared:
  - state=COLLECT, slot count=0.
  - num1..num4=0, epsilon=0, mx_start=0.
  - res_max=0, res_index=0, res_err=0, res_valid=0.
  - Watchdog=0. in_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons any set in progress; a late mx_done is ignored.
- Sanitization, applied per word on accept:
  - Sign bit set (any negative value, -0, -Inf) → 32'h0000_0000.
  - NaN (exponent 8'hFF, mantissa ≠ 0) → 32'h0000_0000.
  - +Inf and denormals pass unchanged.
- COLLECT:
  - in_ready=1. Each in_valid&in_ready cycle writes the sanitized word to slot cnt, then cnt++.
  - The word accepted at cnt=3 also latches eps_cfg into epsilon, clears cnt, and moves to LAUNCH.
- LAUNCH: exactly one cycle. mx_start=1, in_ready=0. Next state is WAIT; watchdog cleared.
- WAIT:
  - in_ready=0; num*/epsilon held stable. The watchdog increments each cycle.
  - If mx_done=1: capture mx_max into res_max, compute res_index/res_err (see match rule), set res_valid=1, go to RESULT.
  - If instead the watchdog reaches TIMEOUT_CYCLES-1 without done: res_max=0, res_index=0, res_err=1, res_valid=1, go to RESULT.
  - If done and timeout coincide in the same cycle, done wins.
- Match rule:
  - res_index is the lowest i with num(i+1) bitwise equal to mx_max, so ties resolve to the lowest slot.
  - If no slot matches, res_index=0 and res_err=1.
- RESULT:
  - res_valid held high and res_* stable until res_valid&res_ready.
  - On that handshake: res_valid=0 next cycle, return to COLLECT.
  - in_ready=0 throughout RESULT, so at most one set is in flight.
  - num*/epsilon keep their last values until overwritten.
- mx_done outside WAIT is ignored. mx_start is never asserted outside LAUNCH.
- Latency, 4th accept → mx_start: 1 cycle. mx_done → res_valid: 1 cycle.
- Purely combinational logic on the data path: sanitize and equality compare only; no FP arithmetic.

Decomposition:
- Package maxnet_pkg:
  - State encoding: COLLECT, LAUNCH, WAIT, RESULT.
  - FP32 constants: FP_ZERO=32'h0, EXP_ALL1=8'hFF.
  - Function is_nan.
- Sub-module fp32_sanitize: combinational, in[31:0] → out[31:0].
  - Used once on the input path.
  - Unit-testable on its own.

Test Plan:
- Nominal set: stream 3ECCCCCD (0.4), 3FCCCCCD (1.6), 3FD9999A (1.7), 3FA66666 (1.3) with eps_cfg=3E99999A, using a stub Maxnet that returns 3FD9999A after 5 cycles. Required: mx_start pulses once, 1 cycle after the 4th accept; num1..4/epsilon match the inputs; res_max=3FD9999A, res_index=2, res_err=0.
- Sanitize: inputs BF800000 (-1.0), 7FC00000 (NaN), 80000000 (-0), 3F800000. Required: num1=num2=num3=0, num4=3F800000.
- Tie and backpressure: inputs 3F800000, 40000000, 40000000, 3F000000 with stub max 40000000, res_ready held 0 for 10 cycles. Required: res_index=1; res_valid and res_* held stable; in_ready=0 until the handshake, then in_ready=1.
- Timeout: stub never raises done, TIMEOUT_CYCLES=16. Required: res_valid exactly 16 cycles after mx_start, with res_err=1, res_max=0. A late mx_done is ignored.
- Mismatch: stub returns 3F000001 for the nominal set. Required: res_err=1, res_index=0.
- Reset mid-WAIT: assert rst for 1 cycle. Required: all outputs 0, in_ready=1 next cycle; the following mx_done pulse is ignored; the next set of 4 processes normally.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared types, constants and helpers for the Maxnet feeder.
//   state_t   - feeder FSM states (COLLECT, LAUNCH, WAIT, RESULT)
//   FP_ZERO   - FP32 +0.0 bit pattern
//   EXP_ALL1  - FP32 exponent value used by Inf/NaN encodings
//   is_nan()  - true for any FP32 NaN (quiet or signalling, either sign)
package maxnet_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == EXP_ALL1) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp32_sanitize.sv
// fp32_sanitize: combinational FP32 clean-up in front of Maxnet.
//   din  [31:0] - raw FP32 word
//   dout [31:0] - +0.0 for any word with the sign bit set (negatives, -0,
//                 -Inf) or any NaN; every other word (including +Inf and
//                 denormals) passes through unchanged.
module fp32_sanitize
    import maxnet_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        if (din[31] || is_nan(din)) begin
            dout = FP_ZERO;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/maxnet_feeder.sv
// maxnet_feeder: groups a stream of FP32 activations into sets of four,
// sanitizes them, runs one Maxnet pass per set and returns the winner.
//
// Ports
//   clk, rst              - clock (rising edge), synchronous active-high reset
//   in_data/in_valid/in_ready
//                         - activation stream; a word moves on a cycle where
//                           in_valid and in_ready are both 1
//   eps_cfg               - epsilon, sampled together with the 4th word
//   num1..num4, epsilon   - operands presented to Maxnet, stable from launch
//                           until the next set overwrites them
//   mx_start              - one-cycle start pulse to Maxnet
//   mx_max, mx_done       - Maxnet result; only looked at while waiting
//   res_max/res_index/res_err/res_valid/res_ready
//                         - result handshake; a result is consumed on a cycle
//                           where res_valid and res_ready are both 1, and
//                           res_* stay stable while res_valid waits for ready
//
// Handshake rule used on both sides: the producer holds valid and data
// stable until the cycle where ready is also 1; the transfer happens on that
// rising edge. Only one set is ever in flight: input is refused from the 4th
// accepted word until the result has been consumed.
module maxnet_feeder
    import maxnet_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] eps_cfg,
    output logic [31:0] num1,
    output logic [31:0] num2,
    output logic [31:0] num3,
    output logic [31:0] num4,
    output logic [31:0] epsilon,
    output logic        mx_start,
    input  logic [31:0] mx_max,
    input  logic        mx_done,
    output logic [31:0] res_max,
    output logic [1:0]  res_index,
    output logic        res_err,
    output logic        res_valid,
    input  logic        res_ready
);

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] slot_q [4];
    logic [31:0] eps_q;
    logic [TW-1:0] wd;

    logic [31:0] san_data;
    logic [1:0]  match_idx;
    logic        match_hit;

    fp32_sanitize u_sanitize (
        .din  (in_data),
        .dout (san_data)
    );

    assign num1    = slot_q[0];
    assign num2    = slot_q[1];
    assign num3    = slot_q[2];
    assign num4    = slot_q[3];
    assign epsilon = eps_q;

    // Scan from slot 3 down so the lowest matching slot is the one left.
    always_comb begin
        match_idx = 2'd0;
        match_hit = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_q[i] == mx_max) begin
                match_idx = 2'(i);
                match_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= 2'd0;
            for (int i = 0; i < 4; i++) slot_q[i] <= FP_ZERO;
            eps_q     <= FP_ZERO;
            mx_start  <= 1'b0;
            res_max   <= FP_ZERO;
            res_index <= 2'd0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            wd        <= '0;
            in_ready  <= 1'b1;
        end else begin
            mx_start <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        slot_q[cnt] <= san_data;
                        cnt         <= cnt + 2'd1;   // wraps to 0 after slot 3
                        if (cnt == 2'd3) begin
                            eps_q    <= eps_cfg;
                            in_ready <= 1'b0;
                            mx_start <= 1'b1;        // high during LAUNCH
                            state    <= LAUNCH;
                        end
                    end
                end

                LAUNCH: begin
                    wd    <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    wd <= wd + 1'b1;
                    if (mx_done) begin
                        // done has priority over a coinciding timeout
                        res_max   <= mx_max;
                        res_index <= match_hit ? match_idx : 2'd0;
                        res_err   <= ~match_hit;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else if (wd == TW'(TIMEOUT_CYCLES - 2)) begin
                        // the watchdog reaches TIMEOUT_CYCLES-1 on this edge,
                        // which puts res_valid TIMEOUT_CYCLES cycles after start
                        res_max   <= FP_ZERO;
                        res_index <= 2'd0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end

                RESULT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= COLLECT;
                    end
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_feeder.sv
module tb_maxnet_feeder;

  localparam int T   = 16;
  localparam int TWB = 5;
  localparam int W   = 35;  // {err, index[1:0], max[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] eps_cfg;
  logic [31:0] num1, num2, num3, num4, epsilon;
  logic        mx_start;
  logic [31:0] mx_max;
  logic        mx_done;
  logic [31:0] res_max;
  logic [1:0]  res_index;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  maxnet_feeder #(.TIMEOUT_CYCLES(T), .TW(TWB)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .eps_cfg(eps_cfg),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4), .epsilon(epsilon),
    .mx_start(mx_start), .mx_max(mx_max), .mx_done(mx_done),
    .res_max(res_max), .res_index(res_index), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  // ---------------- reference model ----------------
  // A word Maxnet may see: negatives (incl. -0, -Inf) and NaNs become +0.
  function automatic logic [31:0] ref_sanitize(input logic [31:0] v);
    logic neg;
    logic nan;
    neg = v[31];
    nan = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    return (neg || nan) ? 32'h0 : v;
  endfunction

  // Numerically largest of four non-negative FP32 values.
  function automatic logic [31:0] ref_max(input logic [31:0] a, b, c, d);
    logic [31:0] best;
    best = a;
    if ($bitstoshortreal(b) > $bitstoshortreal(best)) best = b;
    if ($bitstoshortreal(c) > $bitstoshortreal(best)) best = c;
    if ($bitstoshortreal(d) > $bitstoshortreal(best)) best = d;
    return best;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = {1'b1, 31'($urandom)};                       // negative
      1: v = {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))}; // NaN
      2: v = 32'h7F80_0000;                               // +Inf
      3: v = {1'b0, 8'h00, 23'($urandom)};                // denormal/zero
      default: v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full set: stream four words, act as Maxnet stub (done after 'delay'
  // cycles, never if delay<0), then hold res_ready low for 'hold' cycles.
  task automatic run_set(input logic [31:0] w0, w1, w2, w3, input logic [31:0] eps,
                         input int delay, input logic [31:0] stub_val, input int hold,
                         input string tag);
    logic [31:0] s0, s1, s2, s3;
    logic [W-1:0] exp_res;
    logic [W-1:0] got;
    logic [1:0] idx;
    logic hit;
    int exp_lat;
    int k;
    bit seen;

    s0 = ref_sanitize(w0); s1 = ref_sanitize(w1);
    s2 = ref_sanitize(w2); s3 = ref_sanitize(w3);

    if (delay >= 1 && delay <= T - 1) begin
      hit = 1'b1;
      if (s0 == stub_val) idx = 2'd0;
      else if (s1 == stub_val) idx = 2'd1;
      else if (s2 == stub_val) idx = 2'd2;
      else if (s3 == stub_val) idx = 2'd3;
      else begin idx = 2'd0; hit = 1'b0; end
      exp_res = {~hit, idx, stub_val};
      exp_lat = delay + 1;
    end else begin
      exp_res = {1'b1, 2'd0, 32'h0};
      exp_lat = T;
    end
    exp_q.push_back(exp_res);

    eps_cfg = eps;
    send_word(w0);
    send_word(w1);
    send_word(w2);
    eps_cfg = eps;
    send_word(w3);
    eps_cfg = $urandom;  // must not matter after the 4th accept

    checks++;
    if (mx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start_pulse: mx_start=%b required 1", tag, mx_start);
    end
    checks++;
    if ({num1, num2, num3, num4, epsilon} !== {s0, s1, s2, s3, eps}) begin
      errors++;
      $display("FAIL %s operands: got %h %h %h %h eps %h required %h %h %h %h eps %h",
               tag, num1, num2, num3, num4, epsilon, s0, s1, s2, s3, eps);
    end

    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checks++;
        if (mx_start !== 1'b0) begin
          errors++;
          $display("FAIL %s start_once: mx_start=%b required 0", tag, mx_start);
        end
      end
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        mx_done = 1'b0;
      end else if (k == delay) begin
        mx_done = 1'b1;
        mx_max  = stub_val;
      end else begin
        mx_done = 1'b0;
        mx_max  = $urandom;
      end
    end
    mx_done = 1'b0;

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s result_wait: res_valid never rose in 40 cycles", tag);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (k != exp_lat) begin
      errors++;
      $display("FAIL %s latency: res_valid after %0d cycles, required %0d", tag, k, exp_lat);
    end

    exp_res = exp_q.pop_front();
    got = {res_err, res_index, res_max};
    checks++;
    if (got !== exp_res) begin
      errors++;
      $display("FAIL %s result: err=%b idx=%0d max=%h required err=%b idx=%0d max=%h",
               tag, got[34], got[33:32], got[31:0], exp_res[34], exp_res[33:32], exp_res[31:0]);
    end
    checks++;
    if ({num1, num2, num3, num4} !== {s0, s1, s2, s3}) begin
      errors++;
      $display("FAIL %s operands_held: got %h %h %h %h", tag, num1, num2, num3, num4);
    end

    // backpressure: result must sit still, stray done pulses ignored
    for (int h = 0; h < hold; h++) begin
      mx_done = 1'($urandom_range(0, 1));
      mx_max  = $urandom;
      @(negedge clk);
      checks++;
      if ({res_valid, in_ready, res_err, res_index, res_max} !== {2'b10, exp_res}) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b in_ready=%b err=%b idx=%0d max=%h",
                 tag, h, res_valid, in_ready, res_err, res_index, res_max);
      end
    end
    mx_done = 1'b0;

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: res_valid=%b in_ready=%b required 0/1", tag, res_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({num1, num2, num3, num4, epsilon, mx_start, res_max, res_index, res_err, res_valid, in_ready}
        !== {160'h0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: nums %h %h %h %h eps %h start %b res %h/%0d/%b/%b in_ready %b",
               num1, num2, num3, num4, epsilon, mx_start, res_max, res_index, res_err, res_valid, in_ready);
    end
  endtask

  task automatic test_nominal();
    run_set(32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666, 32'h3E99999A,
            5, 32'h3FD9999A, 0, "nominal");
  endtask

  task automatic test_sanitize();
    run_set(32'hBF800000, 32'h7FC00000, 32'h80000000, 32'h3F800000, 32'h3E99999A,
            3, 32'h3F800000, 1, "sanitize");
    // +Inf and denormal pass, -Inf cleared
    run_set(32'h7F800000, 32'h00000001, 32'hFF800000, 32'h7F800001, 32'h00000000,
            4, 32'h7F800000, 0, "sanitize_inf");
  endtask

  task automatic test_tie_backpressure();
    run_set(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3E99999A,
            5, 32'h40000000, 10, "tie_bp");
  endtask

  task automatic test_timeout();
    run_set(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E99999A,
            -1, 32'h40400000, 4, "timeout");
  endtask

  task automatic test_boundary();
    // done in the very cycle the watchdog expires: done wins
    run_set(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E99999A,
            T - 1, 32'h40400000, 0, "done_at_limit");
    // done one cycle too late: timeout result
    run_set(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E99999A,
            T, 32'h40400000, 0, "done_late");
  endtask

  task automatic test_mismatch();
    run_set(32'h3ECCCCCD, 32'h3FCCCCCD, 32'h3FD9999A, 32'h3FA66666, 32'h3E99999A,
            5, 32'h3F000001, 0, "mismatch");
  endtask

  task automatic test_reset_mid_wait();
    eps_cfg = 32'h3E99999A;
    send_word(32'h3F800000);
    send_word(32'h40000000);
    send_word(32'h40400000);
    send_word(32'h3F000000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({num1, num2, num3, num4, epsilon, mx_start, res_max, res_index, res_err, res_valid, in_ready}
        !== {160'h0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_wait: nums %h %h %h %h eps %h start %b res %h/%0d/%b/%b in_ready %b",
               num1, num2, num3, num4, epsilon, mx_start, res_max, res_index, res_err, res_valid, in_ready);
    end
    mx_done = 1'b1;
    mx_max  = 32'h40400000;
    @(negedge clk);
    mx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || mx_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_done_ignored: res_valid=%b mx_start=%b in_ready=%b required 0/0/1",
               res_valid, mx_start, in_ready);
    end
    test_nominal();
  endtask

  task automatic test_random();
    logic [31:0] w [4];
    logic [31:0] sv;
    int d;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        w[i] = rand_word();
        if (i > 0 && $urandom_range(0, 4) == 0) w[i] = w[i-1];
      end
      if ($urandom_range(0, 3) != 0)
        sv = ref_max(ref_sanitize(w[0]), ref_sanitize(w[1]), ref_sanitize(w[2]), ref_sanitize(w[3]));
      else
        sv = $urandom;
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, T - 1));
      run_set(w[0], w[1], w[2], w[3], $urandom, d, sv, $urandom_range(0, 3), "random");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    eps_cfg   = '0;
    mx_max    = '0;
    mx_done   = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_sanitize();
    test_tie_backpressure();
    test_timeout();
    test_boundary();
    test_mismatch();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
